// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cache-pair memory arbiter.
package mem_arb_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int ADDR_W  = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_RD   = 3'd1,
        D_RD   = 3'd2,
        D_WR   = 3'd3,
        I_DONE = 3'd4,
        D_DONE = 3'd5
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    // Select 64-bit beat idx of a cacheline, beat 0 being the low bits.
    function automatic logic [BURST_W-1:0] line_slice(input logic [LINE_W-1:0] line,
                                                      input logic [1:0]        idx);
        logic [BURST_W-1:0] beat;
        case (idx)
            2'd0:    beat = line[0*BURST_W +: BURST_W];
            2'd1:    beat = line[1*BURST_W +: BURST_W];
            2'd2:    beat = line[2*BURST_W +: BURST_W];
            2'd3:    beat = line[3*BURST_W +: BURST_W];
            default: beat = {BURST_W{1'b0}};
        endcase
        return beat;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-pair plus physical-memory signal bundle. The arbiter uses the
// slave view; the environment (caches and memory) uses the master view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic [ADDR_W-1:0]  i_addr;
    logic               i_read;
    logic [LINE_W-1:0]  i_rdata;
    logic               i_resp;

    logic [ADDR_W-1:0]  d_addr;
    logic               d_read;
    logic               d_write;
    logic [LINE_W-1:0]  d_wdata;
    logic [LINE_W-1:0]  d_rdata;
    logic               d_resp;

    logic [ADDR_W-1:0]  pmem_address;
    logic               pmem_read;
    logic               pmem_write;
    logic [BURST_W-1:0] pmem_wdata;
    logic [BURST_W-1:0] pmem_rdata;
    logic               pmem_resp;

    modport slave (
        input  i_addr, i_read, d_addr, d_read, d_write, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_address, pmem_read, pmem_write, pmem_wdata
    );

    modport master (
        output i_addr, i_read, d_addr, d_read, d_write, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_address, pmem_read, pmem_write, pmem_wdata
    );

endinterface

// File: rtl/mem_arb_burst.sv
// Beat sequencing for one burst: beat counter and read line assembly.
module mem_arb_burst
    import mem_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               active,
    input  logic               rd_en,
    input  logic               beat_ok,
    input  logic [BURST_W-1:0] rdata,
    output logic [1:0]         beat,
    output logic               last_beat,
    output logic [LINE_W-1:0]  line
);

    logic [1:0]        beat_r;
    logic [LINE_W-1:0] line_r;

    // Beat counter: advances on every accepted beat, wraps to 0 after the fourth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_r <= 2'd0;
        end else if (active && beat_ok) begin
            beat_r <= beat_r + 2'd1;
        end else begin
            beat_r <= beat_r;
        end
    end

    // Line buffer: each read beat lands in its 64-bit slot; held between reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_r <= {LINE_W{1'b0}};
        end else if (active && rd_en && beat_ok) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_r == 2'(k)) begin
                    line_r[k*BURST_W +: BURST_W] <= rdata;
                end
            end
        end else begin
            line_r <= line_r;
        end
    end

    assign beat      = beat_r;
    assign last_beat = (beat_r == 2'(BEATS - 1));
    assign line      = line_r;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter putting the icache and dcache onto one burst memory port.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_t        state_r;
    req_id_t           last_r;
    logic [ADDR_W-1:0] addr_r;

    logic [1:0]        beat_s;
    logic              last_beat_s;
    logic [LINE_W-1:0] line_s;

    logic d_req_s;
    logic grant_d_s;
    logic rd_burst_s;
    logic wr_burst_s;
    logic busy_s;
    logic beat_done_s;

    // Request decode and state-derived burst qualifiers
    always_comb begin
        d_req_s   = bus.d_read | bus.d_write;
        grant_d_s = 1'b0;
        if (d_req_s && (!bus.i_read || (last_r == REQ_I))) begin
            grant_d_s = 1'b1;
        end else begin
            grant_d_s = 1'b0;
        end
        rd_burst_s  = (state_r == I_RD) || (state_r == D_RD);
        wr_burst_s  = (state_r == D_WR);
        busy_s      = rd_burst_s || wr_burst_s;
        beat_done_s = bus.pmem_resp && last_beat_s;
    end

    mem_arb_burst u_burst (
        .clk       (clk),
        .rst       (rst),
        .active    (busy_s),
        .rd_en     (rd_burst_s),
        .beat_ok   (bus.pmem_resp),
        .rdata     (bus.pmem_rdata),
        .beat      (beat_s),
        .last_beat (last_beat_s),
        .line      (line_s)
    );

    // Arbitration FSM: grant in IDLE, run the burst, pulse resp, return to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            last_r  <= REQ_D;
            addr_r  <= {ADDR_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_d_s) begin
                        addr_r <= bus.d_addr;
                        if (bus.d_write) begin
                            state_r <= D_WR;
                        end else begin
                            state_r <= D_RD;
                        end
                    end else if (bus.i_read) begin
                        addr_r  <= bus.i_addr;
                        state_r <= I_RD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                I_RD: begin
                    if (beat_done_s) begin
                        state_r <= I_DONE;
                        last_r  <= REQ_I;
                    end else begin
                        state_r <= I_RD;
                    end
                end
                D_RD, D_WR: begin
                    if (beat_done_s) begin
                        state_r <= D_DONE;
                        last_r  <= REQ_D;
                    end else begin
                        state_r <= state_r;
                    end
                end
                I_DONE, D_DONE: state_r <= IDLE;
                default:        state_r <= IDLE;
            endcase
        end
    end

    // Moore output decode from state, granted address and beat index
    always_comb begin
        bus.pmem_read    = rd_burst_s;
        bus.pmem_write   = wr_burst_s;
        bus.pmem_address = {ADDR_W{1'b0}};
        if (busy_s) begin
            bus.pmem_address = addr_r;
        end else begin
            bus.pmem_address = {ADDR_W{1'b0}};
        end
        bus.pmem_wdata = {BURST_W{1'b0}};
        if (wr_burst_s) begin
            bus.pmem_wdata = line_slice(bus.d_wdata, beat_s);
        end else begin
            bus.pmem_wdata = {BURST_W{1'b0}};
        end
        bus.i_resp  = (state_r == I_DONE);
        bus.d_resp  = (state_r == D_DONE);
        bus.i_rdata = line_s;
        bus.d_rdata = line_s;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural memory responder.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder state (mode 0: beat every active cycle, 1: resp held high, 2: 3-cycle gaps)
    int           mode = 0;
    logic [255:0] rd_line = 256'd0;
    int           beat_cnt = 0;
    int           gap_cnt = 0;
    bit           prev_active = 1'b0;
    logic [31:0]  burst_addr = 32'd0;
    bit           addr_bad = 1'b0;
    bit           saw_rd = 1'b0;
    bit           saw_wr = 1'b0;
    logic [63:0]  wlog [8];

    initial begin : responder
        bit act;
        bit fire;
        int idx;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = 64'd0;
        forever begin
            @(negedge clk);
            act = bus.pmem_read || bus.pmem_write;
            if (act && !prev_active) begin
                beat_cnt   = 0;
                gap_cnt    = 0;
                burst_addr = bus.pmem_address;
                addr_bad   = 1'b0;
                saw_rd     = 1'b0;
                saw_wr     = 1'b0;
            end
            if (act) begin
                if (bus.pmem_address !== burst_addr) addr_bad = 1'b1;
                if (bus.pmem_read)  saw_rd = 1'b1;
                if (bus.pmem_write) saw_wr = 1'b1;
            end
            fire = 1'b0;
            case (mode)
                0: fire = act;
                1: fire = 1'b1;
                default: begin
                    if (act) begin
                        if (gap_cnt == 3) begin
                            fire    = 1'b1;
                            gap_cnt = 0;
                        end else begin
                            gap_cnt++;
                        end
                    end
                end
            endcase
            bus.pmem_resp = fire;
            if (fire && act) begin
                idx = beat_cnt % 4;
                bus.pmem_rdata = rd_line[idx*64 +: 64];
                if (beat_cnt < 8) wlog[beat_cnt] = bus.pmem_wdata;
                beat_cnt++;
            end else begin
                bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            prev_active = act;
        end
    end

    // Wait (bounded) for the wanted resp; count negedges and any resp from the other side
    task automatic wait_resp(input bit want_d, input int limit,
                             output int n, output bit got, output int stray);
        n = 0;
        got = 1'b0;
        stray = 0;
        while (!got && n < limit) begin
            @(negedge clk);
            n++;
            if (want_d ? bus.d_resp : bus.i_resp) got = 1'b1;
            if (want_d ? bus.i_resp : bus.d_resp) stray++;
        end
    endtask

    typedef struct {
        string        name;
        bit           is_d;
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        int           mode;
        logic [255:0] beats;
        logic [255:0] wdata;
        logic [255:0] exp_line;
        int           exp_lat;
    } vec_t;

    localparam logic [255:0] L_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    localparam logic [255:0] L_B = 256'hA0A0A0A0A0A0A0A0_B1B1B1B1B1B1B1B1_C2C2C2C2C2C2C2C2_D3D3D3D3D3D3D3D3;
    localparam logic [255:0] L_C = 256'h0F0F0F0F0F0F0F0F_1234567812345678_CAFEF00DCAFEF00D_8765432187654321;
    localparam logic [255:0] W1  = 256'h0123456789ABCDEF_AAAABBBBCCCCDDDD_5A5A5A5AA5A5A5A5_FEDCBA9876ABCDEF;

    vec_t vecs [7];

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int  n;
        bit  got;
        int  stray;
        logic [255:0] w_exp;

        bus.i_addr  = 32'd0;
        bus.i_read  = 1'b0;
        bus.d_addr  = 32'd0;
        bus.d_read  = 1'b0;
        bus.d_write = 1'b0;
        bus.d_wdata = 256'd0;

        vecs[0] = '{"i_rd",   1'b0, 1'b1, 1'b0, 32'h0000_0060, 0, L_A, 256'd0, L_A, 5};
        vecs[1] = '{"d_wr",   1'b1, 1'b0, 1'b1, 32'h0000_1000, 0, L_B, W1,     L_A, 5};
        vecs[2] = '{"d_rd",   1'b1, 1'b1, 1'b0, 32'h0000_2000, 0, L_B, 256'd0, L_B, 5};
        vecs[3] = '{"d_rw",   1'b1, 1'b1, 1'b1, 32'h0000_3000, 0, L_A, L_C,    L_B, 5};
        vecs[4] = '{"i_hold", 1'b0, 1'b1, 1'b0, 32'h0000_00A0, 1, L_C, 256'd0, L_C, 5};
        vecs[5] = '{"d_rd2",  1'b1, 1'b1, 1'b0, 32'h0000_2020, 0, L_A, 256'd0, L_A, 5};
        vecs[6] = '{"i_gap",  1'b0, 1'b1, 1'b0, 32'h0000_0080, 2, L_C, 256'd0, L_C, 17};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_i_resp",    bus.i_resp, 0);
        chk("rst_d_resp",    bus.d_resp, 0);
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_wr",   bus.pmem_write, 0);
        chk("rst_pmem_addr", bus.pmem_address, 0);
        chk("rst_pmem_wd",   bus.pmem_wdata, 0);
        chk("rst_i_rdata",   bus.i_rdata, 0);
        chk("rst_d_rdata",   bus.d_rdata, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_pmem_read", bus.pmem_read, 0);

        // Tie from reset: icache first, dcache 2 cycles after i_resp, then icache waits
        mode = 0;
        rd_line = L_A;
        bus.i_addr = 32'h0000_0040;
        bus.d_addr = 32'h0000_4000;
        bus.i_read = 1'b1;
        bus.d_read = 1'b1;
        wait_resp(1'b0, 60, n, got, stray);
        chk("tie1_i_resp",  got, 1);
        chk("tie1_stray",   stray, 0);
        chk("tie1_lat",     n, 5);
        chk("tie1_addr",    burst_addr, 32'h0000_0040);
        chk("tie1_i_rdata", bus.i_rdata, L_A);
        rd_line = L_B;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.pmem_read) got = 1'b1;
        end
        chk("tie_d_start",  n, 2);
        chk("tie_d_addr",   bus.pmem_address, 32'h0000_4000);
        wait_resp(1'b1, 60, n, got, stray);
        chk("tie2_d_resp",  got, 1);
        chk("tie2_i_waits", stray, 0);
        chk("tie2_d_rdata", bus.d_rdata, L_B);
        bus.d_read = 1'b0;
        rd_line = L_C;
        wait_resp(1'b0, 60, n, got, stray);
        chk("tie3_i_resp",  got, 1);
        chk("tie3_addr",    burst_addr, 32'h0000_0040);
        chk("tie3_i_rdata", bus.i_rdata, L_C);
        bus.i_read = 1'b0;
        @(negedge clk);

        // Table-driven single transfers
        for (int v = 0; v < 7; v++) begin
            mode = vecs[v].mode;
            rd_line = vecs[v].beats;
            bus.d_wdata = vecs[v].wdata;
            if (vecs[v].is_d) begin
                bus.d_addr  = vecs[v].addr;
                bus.d_read  = vecs[v].rd;
                bus.d_write = vecs[v].wr;
            end else begin
                bus.i_addr = vecs[v].addr;
                bus.i_read = 1'b1;
            end
            wait_resp(vecs[v].is_d, 80, n, got, stray);
            chk({vecs[v].name, "_resp"},  got, 1);
            chk({vecs[v].name, "_stray"}, stray, 0);
            chk({vecs[v].name, "_lat"},   n, vecs[v].exp_lat);
            chk({vecs[v].name, "_beats"}, beat_cnt, 4);
            chk({vecs[v].name, "_addr"},  burst_addr, vecs[v].addr);
            chk({vecs[v].name, "_addr_stable"}, addr_bad, 0);
            chk({vecs[v].name, "_saw_rd"}, saw_rd, !vecs[v].wr);
            chk({vecs[v].name, "_saw_wr"}, saw_wr, vecs[v].wr);
            chk({vecs[v].name, "_i_rdata"}, bus.i_rdata, vecs[v].exp_line);
            chk({vecs[v].name, "_d_rdata"}, bus.d_rdata, vecs[v].exp_line);
            if (vecs[v].wr) begin
                w_exp = vecs[v].wdata;
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("%s_wbeat%0d", vecs[v].name, k), wlog[k], w_exp[k*64 +: 64]);
                end
            end
            bus.i_read  = 1'b0;
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
            @(negedge clk);
            chk({vecs[v].name, "_pulse"}, vecs[v].is_d ? bus.d_resp : bus.i_resp, 0);
        end

        // Reset in the middle of an icache burst
        mode = 0;
        rd_line = L_A;
        bus.i_addr = 32'h0000_0060;
        bus.i_read = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_pmem_read", bus.pmem_read, 0);
        chk("abort_pmem_addr", bus.pmem_address, 0);
        chk("abort_line_clr",  bus.i_rdata, 0);
        bus.i_read = 1'b0;
        stray = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.i_resp) stray++;
        end
        chk("abort_no_resp", stray, 0);
        rst = 1'b1;
        @(negedge clk);
        bus.i_read = 1'b1;
        wait_resp(1'b0, 60, n, got, stray);
        chk("retry_resp",    got, 1);
        chk("retry_lat",     n, 5);
        chk("retry_beats",   beat_cnt, 4);
        chk("retry_i_rdata", bus.i_rdata, L_A);
        bus.i_read = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
